// File: rtl/raster_pkg.sv
// Shared types and width helpers for the triangle rasterizer stages.
package raster_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Edge function magnitude: 2*WIDTH bits of product, plus sum carry and sign.
    function automatic int edge_width(input int width);
        return 2 * width + 3;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] x;
        logic [DEFAULT_WIDTH-1:0] y;
    } vertex_t;

endpackage

// File: rtl/edge_stepper.sv
// Incremental edge-function accumulator: steps by A along a row, by B per row.
module edge_stepper
    import raster_pkg::*;
#(
    parameter int EDGE_W = edge_width(DEFAULT_WIDTH)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load,
    input  logic                     step_x,
    input  logic                     step_y,
    input  logic signed [EDGE_W-1:0] a,
    input  logic signed [EDGE_W-1:0] b,
    input  logic signed [EDGE_W-1:0] e0,
    output logic signed [EDGE_W-1:0] e,
    output logic                     ge0,
    output logic                     le0
);

    logic signed [EDGE_W-1:0] row_e;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e     <= '0;
            row_e <= '0;
        end else if (load) begin
            e     <= e0;
            row_e <= e0;
        end else if (step_y) begin
            e     <= row_e + b;
            row_e <= row_e + b;
        end else if (step_x) begin
            e <= e + a;
        end
    end

    assign ge0 = !e[EDGE_W-1];
    assign le0 = e[EDGE_W-1] || (e == '0);

endmodule

// File: rtl/max.sv
// Three-input unsigned maximum.
module max #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] ab;

    assign ab = (a > b) ? a : b;
    assign y  = (ab > c) ? ab : c;

endmodule

// File: rtl/min.sv
// Three-input unsigned minimum.
module min #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] ab;

    assign ab = (a < b) ? a : b;
    assign y  = (ab < c) ? ab : c;

endmodule

// File: rtl/tri_raster_walker.sv
// Triangle scan conversion: bounding-box walk with three incremental edge functions,
// emitting covered pixels on a valid/ready stream.
module tri_raster_walker
    import raster_pkg::*;
#(
    parameter int  WIDTH  = DEFAULT_WIDTH,
    localparam int EDGE_W = edge_width(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             done,
    output logic             busy
);

    state_t                   state;
    logic [WIDTH-1:0]         vx [3];
    logic [WIDTH-1:0]         vy [3];
    logic [WIDTH-1:0]         xmin, xmax, ymin, ymax;
    logic [WIDTH-1:0]         cx, cy;
    logic signed [EDGE_W-1:0] step_a [3];
    logic signed [EDGE_W-1:0] step_b [3];
    logic signed [EDGE_W-1:0] e_start [3];
    logic signed [EDGE_W-1:0] area;
    logic [2:0]               ge0, le0;
    logic                     advance, covered, at_xmax, at_ymax;

    function automatic logic signed [EDGE_W-1:0] zx(input logic [WIDTH-1:0] v);
        return signed'({{(EDGE_W-WIDTH){1'b0}}, v});
    endfunction

    min #(.WIDTH(WIDTH)) u_xmin (.a(vx[0]), .b(vx[1]), .c(vx[2]), .y(xmin));
    max #(.WIDTH(WIDTH)) u_xmax (.a(vx[0]), .b(vx[1]), .c(vx[2]), .y(xmax));
    min #(.WIDTH(WIDTH)) u_ymin (.a(vy[0]), .b(vy[1]), .c(vy[2]), .y(ymin));
    max #(.WIDTH(WIDTH)) u_ymax (.a(vy[0]), .b(vy[1]), .c(vy[2]), .y(ymax));

    assign advance = !out_valid || out_ready;
    assign at_xmax = (cx == xmax);
    assign at_ymax = (cy == ymax);
    assign covered = (&ge0) || (&le0);
    assign busy    = (state != IDLE);

    // Edge i runs from vertex i to vertex (i+1)%3.
    for (genvar i = 0; i < 3; i++) begin : g_edge
        localparam int J = (i + 1) % 3;

        assign step_a[i]  = zx(vy[J]) - zx(vy[i]);
        assign step_b[i]  = zx(vx[i]) - zx(vx[J]);
        assign e_start[i] = (zx(xmin) - zx(vx[i])) * step_a[i]
                          + (zx(ymin) - zx(vy[i])) * step_b[i];

        edge_stepper #(.EDGE_W(EDGE_W)) u_edge (
            .clk    (clk),
            .resetn (resetn),
            .load   (state == SETUP),
            .step_x (state == SCAN && advance && !at_xmax),
            .step_y (state == SCAN && advance && at_xmax && !at_ymax),
            .a      (step_a[i]),
            .b      (step_b[i]),
            .e0     (e_start[i]),
            .e      (),
            .ge0    (ge0[i]),
            .le0    (le0[i])
        );
    end

    assign area = (zx(vx[2]) - zx(vx[0])) * step_a[0]
                + (zx(vy[2]) - zx(vy[0])) * step_b[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            done      <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            vx        <= '{default: '0};
            vy        <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        vx       <= '{x0, x1, x2};
                        vy       <= '{y0, y1, y2};
                        in_ready <= 1'b0;
                        state    <= SETUP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    cx    <= xmin;
                    cy    <= ymin;
                    state <= (area == '0) ? DONE : SCAN;
                end
                SCAN: begin
                    if (advance) begin
                        out_valid <= covered;
                        if (covered) begin
                            out_x <= cx;
                            out_y <= cy;
                        end
                        // Compare before incrementing so xmax/ymax at full scale never wrap.
                        if (at_xmax) begin
                            if (at_ymax) begin
                                state <= DONE;
                            end else begin
                                cx <= xmin;
                                cy <= cy + WIDTH'(1);
                            end
                        end else begin
                            cx <= cx + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tri_raster_walker.md
# tri_raster_walker

Triangle scan-conversion stage of the FPGA rasterizer. It accepts one triangle (three integer vertices) over a valid/ready handshake and computes its bounding box with the existing three-input `min`/`max` modules. It walks every pixel of the box in row-major order, evaluating three incremental edge functions. It emits only covered pixel coordinates on a valid/ready output stream toward the framebuffer writer, and pulses `done` when the triangle is finished.

## Interface
- `WIDTH`, 8: unsigned coordinate width for x and y.
- `EDGE_W`, 2*WIDTH+3: signed edge-accumulator width, derived and not overridden.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: triangle present on `x0..y2`.
- `in_ready` output 1: walker idle and able to accept a triangle.
- `x0, y0, x1, y1, x2, y2` input WIDTH each: vertex coordinates, sampled only on accept.
- `out_valid` output 1: `out_x`/`out_y` holds a covered pixel.
- `out_ready` input 1: downstream consumes the pixel.
- `out_x, out_y` output WIDTH each: covered pixel coordinate.
- `done` output 1: one-cycle pulse after the last pixel of a triangle is consumed.
- `busy` output 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1. On accept (`in_valid & in_ready`), latch the vertices and go to SETUP.
  - SETUP: compute the bounding box (`xmin`, `xmax`, `ymin`, `ymax`) and, per edge ab (01, 12, 20), the step terms `A = yb-ya` and `B = -(xb-xa)`. Compute the start value `E = (xmin-xa)*A + (ymin-ya)*B` and the triangle area `E01` evaluated at vertex 2. If the area is 0, go to DONE; otherwise go to SCAN.
  - SCAN: evaluate one candidate (x,y) per advancing cycle. Go to DONE after evaluating (`xmax`,`ymax`).
  - DONE: wait until the output register is empty or being consumed, pulse `done`, then go to IDLE.
- Coverage test: the pixel is covered if all three E are ≥0, or all three are ≤0. This accepts both windings, and edges are inclusive. Sampling is at integer coordinates with no half-pixel offset.
- Incremental stepping within a row: x+1 and E += A. At row end: x = `xmin`, y+1, and E = rowE + B, where rowE is the value saved at the row start.
- Termination is detected by comparing x==`xmax` and y==`ymax` before incrementing. Counters never wrap, even when `xmax` = 2^WIDTH-1.
- Advance condition: `!out_valid || out_ready`. SCAN stalls entirely otherwise.
- A covered candidate loads the output register and sets `out_valid`. An uncovered candidate is skipped silently.
- `out_x`/`out_y` remain stable while `out_valid & !out_ready`.
- All arithmetic is signed at EDGE_W width. Vertex coordinates are zero-extended before subtraction.

## Timing
- Reset values: `in_ready`=1 (after reset, in IDLE), `out_valid`=0, `out_x`=`out_y`=0, `done`=0, `busy`=0, state IDLE. Reset mid-scan discards the triangle immediately.
- Cycle sequence for an accept at edge T:
  - T+1: SETUP.
  - T+2: (`xmin`,`ymin`) is evaluated.
  - T+3: the earliest `out_valid`.
- Throughput: one candidate per cycle with no stall. A box of W×H candidates takes W*H SCAN cycles.
- Degenerate (zero-area) triangle: `done` at T+3, no pixels emitted.
- `done` is asserted in the cycle after the final output handshake, or in the cycle after the last evaluation if that candidate was uncovered. `in_ready` returns in the following cycle.
- `in_valid` is ignored while `busy`.

## Structure
- Package `raster_pkg`: `WIDTH` default, the `EDGE_W` derivation function, the state enum (IDLE, SETUP, SCAN, DONE), and a vertex struct.
- Sub-module `edge_stepper`, instantiated three times:
  - holds the E accumulator and rowE;
  - ports: load, step_x, step_y, A, B, E0;
  - outputs: E, `ge0`, `le0`.
- The bounding box uses `min`/`max` instances with `WIDTH` passed through.

## Test plan
- Vertices (0,0),(4,0),(0,4) with `out_ready`=1 → exactly 15 pixels in row-major order, first (0,0) and last (0,4), row y=1 is x=0..3, then a single `done` pulse.
- Same triangle with reversed winding (0,0),(0,4),(4,0) → identical 15-pixel sequence.
- Collinear vertices (0,0),(2,2),(4,4) → no `out_valid`, `done` at T+3, `in_ready` at T+4.
- First triangle with `out_ready` random 50% → the same sequence as with `out_ready`=1, and `out_x`/`out_y` stable during every stall.
- Vertices (250,250),(255,250),(255,255) → 21 pixels covering x from 250 to 255, terminating with no wrap past 255.
- Deassert `resetn` during SCAN of the first triangle → `out_valid`=0 and `busy`=0 asynchronously. After release, `in_ready`=1 and a new triangle runs correctly.
